// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared types and constants for the ULA sequencing front-end:
//   cmd_kind_t : command encoding on cmd_kind (LOADI, EXEC, READ, NOP)
//   OP_*       : ULA opcode values carried on cmd_op / alu_op
//   state_t    : sequencer states (IDLE, ISSUE, RESP)
// ---------------------------------------------------------------------------
package ula_pkg;

  typedef enum logic [1:0] {
    LOADI = 2'b00,
    EXEC  = 2'b01,
    READ  = 2'b10,
    NOP   = 2'b11
  } cmd_kind_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;

endpackage

// File: rtl/ula.sv
// ---------------------------------------------------------------------------
// ULA
// Combinational datapath driven by ula_seq.
// Ports:
//   a, b : N-bit operands
//   op   : 000 add, 001 sub, 010 mul (low N bits), 011 and, others or
//   c    : N-bit result, all arithmetic wraps modulo 2^N
// ---------------------------------------------------------------------------
module ULA
  import ula_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] c
);

  // Opcode decode; result width truncates to N bits, giving the wrap.
  always_comb begin
    c = {N{1'b0}};
    case (op)
      OP_ADD:  c = a + b;
      OP_SUB:  c = a - b;
      OP_MUL:  c = a * b;
      OP_AND:  c = a & b;
      default: c = a | b;
    endcase
  end

endmodule

// File: rtl/ula_regfile.sv
// ---------------------------------------------------------------------------
// ula_regfile
// Four N-bit operand registers, one write port, two combinational reads.
// Ports:
//   clk, rst             : clock, synchronous active-high reset (clears all)
//   i_we/i_waddr/i_wdata : write port
//   i_raddr1/o_rdata1    : read port 1
//   i_raddr2/o_rdata2    : read port 2
// ---------------------------------------------------------------------------
module ula_regfile
  import ula_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic [1:0]   i_waddr,
  input  logic [N-1:0] i_wdata,
  input  logic [1:0]   i_raddr1,
  input  logic [1:0]   i_raddr2,
  output logic [N-1:0] o_rdata1,
  output logic [N-1:0] o_rdata2
);

  logic [N-1:0] r_regs [4];

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= {N{1'b0}};
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq
// Command sequencer in front of the ULA datapath.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready               : command handshake (ready only in IDLE)
//   cmd_kind, cmd_op, cmd_rd,
//   cmd_rs1, cmd_rs2, cmd_imm         : command fields
//   alu_a, alu_b, alu_op              : registered drive to the ULA
//   alu_c                             : ULA combinational result
//   res_valid/res_ready               : response handshake
//   res_data, res_rd                  : response payload
// EXEC: accept -> ISSUE (ULA settles) -> RESP. READ: accept -> RESP.
// LOADI and NOP complete in the accept cycle with no response.
// ---------------------------------------------------------------------------
module ula_seq
  import ula_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_kind,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_rd,
  input  logic [1:0]   cmd_rs1,
  input  logic [1:0]   cmd_rs2,
  input  logic [N-1:0] cmd_imm,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_c,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [1:0]   res_rd
);

  state_t       r_state;
  state_t       w_state_nxt;
  cmd_kind_t    w_kind;
  logic         w_accept;
  logic         w_we;
  logic [1:0]   w_waddr;
  logic [N-1:0] w_wdata;
  logic [N-1:0] w_rdata1;
  logic [N-1:0] w_rdata2;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [2:0]   r_alu_op;
  logic [1:0]   r_rd;
  logic         r_res_valid;
  logic [N-1:0] r_res_data;
  logic [1:0]   r_res_rd;

  assign w_kind    = cmd_kind_t'(cmd_kind);
  // Ready is masked by rst so nothing is accepted on a reset edge.
  assign cmd_ready = (r_state == IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  ula_regfile #(.N(N)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr1 (cmd_rs1),
    .i_raddr2 (cmd_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (w_kind)
            EXEC:    w_state_nxt = ISSUE;
            READ:    w_state_nxt = RESP;
            default: w_state_nxt = IDLE;
          endcase
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE:   w_state_nxt = RESP;
      RESP: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; res_valid is registered as "next state is RESP".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_res_valid <= (w_state_nxt == RESP);
    end
  end

  // Register-file write select: ISSUE write-back or an accepted LOADI
  // (the two are mutually exclusive since accept needs IDLE).
  always_comb begin
    w_we    = 1'b0;
    w_waddr = 2'b00;
    w_wdata = {N{1'b0}};
    if (r_state == ISSUE) begin
      w_we    = 1'b1;
      w_waddr = r_rd;
      w_wdata = alu_c;
    end else if (w_accept && (w_kind == LOADI)) begin
      w_we    = 1'b1;
      w_waddr = cmd_rd;
      w_wdata = cmd_imm;
    end else begin
      w_we    = 1'b0;
    end
  end

  // Operand snapshot, ULA drive and response payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= {N{1'b0}};
      r_alu_b    <= {N{1'b0}};
      r_alu_op   <= 3'b000;
      r_rd       <= 2'b00;
      r_res_data <= {N{1'b0}};
      r_res_rd   <= 2'b00;
    end else begin
      if (w_accept && (w_kind == EXEC)) begin
        r_alu_a  <= w_rdata1;
        r_alu_b  <= w_rdata2;
        r_alu_op <= cmd_op;
        r_rd     <= cmd_rd;
      end
      if (w_accept && (w_kind == READ)) begin
        r_res_data <= w_rdata1;
        r_res_rd   <= cmd_rs1;
      end
      if (r_state == ISSUE) begin
        r_res_data <= alu_c;
        r_res_rd   <= r_rd;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_rd    = r_res_rd;

endmodule

// File: tb/tb_ula_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_seq
// Self-checking bench for ula_seq with a ULA instance beside it. Expected
// results come from a register-array model and plain modulo-256 arithmetic.
// ---------------------------------------------------------------------------
module tb_ula_seq;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_kind;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_rd;
  logic [1:0]   cmd_rs1;
  logic [1:0]   cmd_rs2;
  logic [N-1:0] cmd_imm;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_c;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic [1:0]   res_rd;

  int checks = 0;
  int errors = 0;
  int regs_m [4];

  ula_seq #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd)
  );

  ULA #(.N(N)) u_ula (.a(alu_a), .b(alu_b), .op(alu_op), .c(alu_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_op(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return (a * b) % 256;
      3:       return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command, wait (bounded) for ready, return just after the accept edge.
  task automatic send(input int kind, input int op, input int rd, input int rs1,
                      input int rs2, input int imm);
    int n;
    cmd_kind  = 2'(kind);
    cmd_op    = 3'(op);
    cmd_rd    = 2'(rd);
    cmd_rs1   = 2'(rs1);
    cmd_rs2   = 2'(rs2);
    cmd_imm   = 8'(imm);
    cmd_valid = 1'b1;
    #1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("cmd_ready_in_idle", 32'(n), 32'd0);
    step();
    cmd_valid = 1'b0;
    cmd_kind  = 2'b11;
    if (kind == 0) regs_m[rd] = imm % 256;
  endtask

  // Wait for the response, check latency and payload, then its completion.
  task automatic expect_resp(input int lat, input int exp_data, input int exp_rd);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("resp_latency", 32'(n), 32'(lat));
    check("res_data", 32'(res_data), 32'(exp_data));
    check("res_rd", 32'(res_rd), 32'(exp_rd));
    step();
    check("resp_done", 32'(res_valid), 32'd0);
  endtask

  // EXEC with model result, or a fixed expected value when exp_c >= 0.
  task automatic exec(input int op, input int rd, input int rs1, input int rs2, input int exp_c);
    int exp_v;
    int a;
    int b;
    a = regs_m[rs1];
    b = regs_m[rs2];
    exp_v = (exp_c >= 0) ? exp_c : ref_op(op, a, b);
    send(1, op, rd, rs1, rs2, 0);
    check("issue_no_valid", 32'(res_valid), 32'd0);
    check("alu_a", 32'(alu_a), 32'(a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_op", 32'(alu_op), 32'(op));
    expect_resp(1, exp_v, rd);
    regs_m[rd] = exp_v;
  endtask

  task automatic read(input int rs, input int exp_c);
    int exp_v;
    exp_v = (exp_c >= 0) ? exp_c : regs_m[rs];
    send(2, 0, 0, rs, 0, 0);
    expect_resp(0, exp_v, rs);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_res_rd"}, 32'(res_rd), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'b11; cmd_op = 3'b000;
    cmd_rd = 2'b00; cmd_rs1 = 2'b00; cmd_rs2 = 2'b00; cmd_imm = 8'h00;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) regs_m[i] = 0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    read(3, 0);

    // Add wrap
    send(0, 0, 0, 0, 0, 200);
    send(0, 0, 1, 0, 0, 100);
    exec(0, 2, 0, 1, 44);
    read(2, 44);

    // Sub and mul
    exec(1, 3, 1, 0, 156);
    send(0, 0, 0, 0, 0, 20);
    send(0, 0, 1, 0, 0, 13);
    exec(2, 2, 0, 1, 4);

    // Logic ops
    send(0, 0, 0, 0, 0, 'hF0);
    send(0, 0, 1, 0, 0, 'h3C);
    exec(3, 2, 0, 1, 'h30);
    send(0, 0, 1, 0, 0, 'h0F);
    exec(7, 3, 0, 1, 'hFF);

    // Self-operand
    send(0, 0, 0, 0, 0, 5);
    exec(0, 0, 0, 0, 10);
    exec(0, 0, 0, 0, 20);
    read(0, 20);

    // NOP leaves state alone
    send(3, 0, 0, 0, 0, 'h99);
    read(0, 20);

    // Backpressure: response held 5 cycles, pending LOADI stalls
    send(0, 0, 0, 0, 0, 7);
    send(0, 0, 1, 0, 0, 9);
    res_ready = 1'b0;
    send(1, 0, 1, 0, 1, 0);
    step();
    check("bp_first_valid", 32'(res_valid), 32'd1);
    cmd_kind = 2'b00; cmd_rd = 2'd1; cmd_imm = 8'hAA; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid_held", 32'(res_valid), 32'd1);
      check("bp_data_held", 32'(res_data), 32'd16);
      check("bp_rd_held", 32'(res_rd), 32'd1);
      check("bp_cmd_stalled", 32'(cmd_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(res_valid), 32'd1);
    step();
    check("bp_idle_valid", 32'(res_valid), 32'd0);
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_kind = 2'b11;
    regs_m[1] = 'hAA;
    read(1, 'hAA);
    read(0, 7);

    // Reset mid-op: rst during ISSUE of an EXEC to r2
    send(0, 0, 2, 0, 0, 'h55);
    send(1, 0, 2, 0, 1, 0);
    check("issue_before_rst", 32'(res_valid), 32'd0);
    rst = 1'b1;
    step();
    check_all_zero("mid_rst");
    rst = 1'b0;
    #1;
    check("mid_rst_idle", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) regs_m[i] = 0;
    read(2, 0);

    // Randomized commands against the model
    for (int i = 0; i < 80; i++) begin
      int k;
      int op;
      int rd;
      int rs1;
      int rs2;
      k   = $urandom_range(0, 3);
      op  = $urandom_range(0, 7);
      rd  = $urandom_range(0, 3);
      rs1 = $urandom_range(0, 3);
      rs2 = $urandom_range(0, 3);
      case (k)
        0:       send(0, 0, rd, 0, 0, $urandom_range(0, 255));
        1:       exec(op, rd, rs1, rs2, -1);
        2:       read(rs1, -1);
        default: send(3, op, rd, rs1, rs2, $urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < 4; i++) read(i, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
